// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage: field widths, jump/branch opcodes and fetch-FSM states.
package fetch_unit_pkg;

   localparam int NIB_SIZE = 4;

   localparam logic [NIB_SIZE-1:0] OP_JMP = 4'hE;
   localparam logic [NIB_SIZE-1:0] OP_BR  = 4'hF;

   // Fetch FSM encoding, also visible on the fsm_state debug output.
   localparam logic [2:0] FS_IDLE    = 3'd0;
   localparam logic [2:0] FS_HI_REQ  = 3'd1;
   localparam logic [2:0] FS_HI_WAIT = 3'd2;
   localparam logic [2:0] FS_LO_REQ  = 3'd3;
   localparam logic [2:0] FS_LO_WAIT = 3'd4;

   function automatic logic pc_redirect(input logic [NIB_SIZE-1:0] op, input logic cond);
      return (op == OP_JMP) || ((op == OP_BR) && cond);
   endfunction

endpackage

// File: rtl/fetch_unit_insn_decode.sv
// Combinational instruction-register field decode, shared by the fetch stage and the disassembler.
module fetch_unit_insn_decode
   import fetch_unit_pkg::*;
(
   input  logic [15:0]         ir,
   output logic [NIB_SIZE-1:0] opcode,
   output logic                isaluop,
   output logic [NIB_SIZE-1:0] rd,
   output logic [NIB_SIZE-1:0] ra,
   output logic [NIB_SIZE-1:0] rb,
   output logic [7:0]          imm8
);

   // ALU operations occupy the lower half of the opcode space.
   assign opcode  = ir[15:12];
   assign isaluop = ~ir[15];
   assign rd      = ir[11:8];
   assign ra      = ir[7:4];
   assign rb      = ir[3:0];
   assign imm8    = ir[7:0];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns PC and IR, reads each 16-bit instruction as two byte reads (high at PC, low at PC+1).
// Build option FETCH_WAIT_EN adds a mem_ready input that stretches each read until the memory responds.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter int                DATA_W   = 8,
   parameter int                INSN_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                do_fetch,
   input  logic                do_next,
   input  logic                do_reset,
   input  logic                branch_cond,
`ifdef FETCH_WAIT_EN
   input  logic                mem_ready,
`endif
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_read,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                fetch_stall,
   output logic [NIB_SIZE-1:0] opcode,
   output logic                isaluop,
   output logic [NIB_SIZE-1:0] rd,
   output logic [NIB_SIZE-1:0] ra,
   output logic [NIB_SIZE-1:0] rb,
   output logic [7:0]          imm8,
   output logic [ADDR_W-1:0]   pc,
   output logic                proto_err,
   output logic [2:0]          fsm_state
);

   logic [2:0]        state;
   logic [2:0]        state_nx;
   logic [DATA_W-1:0] hi_q;
   logic [INSN_W-1:0] ir;
   logic [ADDR_W-1:0] pc_nx;
   logic              idle;
   logic              rst_any;
   logic              mem_ok;
   logic              wait_hold;

`ifdef FETCH_WAIT_EN
   assign mem_ok    = mem_ready;
   assign wait_hold = 1'b1;
`else
   assign mem_ok    = 1'b1;
   assign wait_hold = 1'b0;
`endif

   assign idle        = (state == FS_IDLE);
   assign rst_any     = reset | do_reset;
   assign fetch_stall = (do_fetch & idle) | ~idle;
   assign fsm_state   = state;

   fetch_unit_insn_decode u_decode (
      .ir      (ir),
      .opcode  (opcode),
      .isaluop (isaluop),
      .rd      (rd),
      .ra      (ra),
      .rb      (rb),
      .imm8    (imm8)
   );

   // A fetch only starts from IDLE when do_next is absent; do_next wins the cycle.
   always_comb begin
      state_nx = state;
      case (state)
         FS_IDLE:    if (do_fetch && !do_next) state_nx = FS_HI_REQ;
         FS_HI_REQ:  state_nx = FS_HI_WAIT;
         FS_HI_WAIT: if (mem_ok) state_nx = FS_LO_REQ;
         FS_LO_REQ:  state_nx = FS_LO_WAIT;
         FS_LO_WAIT: if (mem_ok) state_nx = FS_IDLE;
         default:    state_nx = FS_IDLE;
      endcase
   end

   // With wait states the request stays asserted, at the same address, until the byte is captured.
   always_comb begin
      mem_read = 1'b0;
      mem_addr = '0;
      case (state)
         FS_HI_REQ: begin
            mem_read = 1'b1;
            mem_addr = pc;
         end
         FS_HI_WAIT: begin
            mem_read = wait_hold;
            mem_addr = wait_hold ? pc : '0;
         end
         FS_LO_REQ: begin
            mem_read = 1'b1;
            mem_addr = pc + ADDR_W'(1);
         end
         FS_LO_WAIT: begin
            mem_read = wait_hold;
            mem_addr = wait_hold ? (pc + ADDR_W'(1)) : '0;
         end
         default: begin
            mem_read = 1'b0;
            mem_addr = '0;
         end
      endcase
   end

   always_comb begin
      pc_nx = pc + ADDR_W'(2);
      if (pc_redirect(opcode, branch_cond)) pc_nx = ADDR_W'(imm8);
   end

   always_ff @(posedge clk) begin
      if (rst_any) begin
         state     <= FS_IDLE;
         pc        <= RESET_PC;
         ir        <= '0;
         hi_q      <= '0;
         proto_err <= 1'b0;
      end else begin
         state <= state_nx;
         if (idle && do_next) pc <= pc_nx;
         if ((do_fetch || do_next) && (!idle || (do_fetch && do_next))) proto_err <= 1'b1;
         if ((state == FS_HI_WAIT) && mem_ok) hi_q <= mem_rdata;
         if ((state == FS_LO_WAIT) && mem_ok) ir <= {hi_q, mem_rdata};
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: byte memory model, vector table, corner sequences and a randomized run.
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       reset, do_fetch, do_next, do_reset, branch_cond;
`ifdef FETCH_WAIT_EN
   logic       mem_ready;
   localparam int EXP_READS = 4;
`else
   localparam int EXP_READS = 2;
`endif
   logic [7:0] mem_addr;
   logic       mem_read;
   logic [7:0] mem_rdata = 8'h00;
   logic       fetch_stall;
   logic [3:0] opcode, rd, ra, rb;
   logic       isaluop;
   logic [7:0] imm8, pc;
   logic       proto_err;
   logic [2:0] fsm_state;

   fetch_unit dut (
      .clk(clk), .reset(reset), .do_fetch(do_fetch), .do_next(do_next), .do_reset(do_reset),
      .branch_cond(branch_cond),
`ifdef FETCH_WAIT_EN
      .mem_ready(mem_ready),
`endif
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata), .fetch_stall(fetch_stall),
      .opcode(opcode), .isaluop(isaluop), .rd(rd), .ra(ra), .rb(rb), .imm8(imm8), .pc(pc),
      .proto_err(proto_err), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [256];
   always @(posedge clk) if (mem_read) mem_rdata <= mem[mem_addr];

   int vectors = 0;
   int miscompares = 0;
   int m_pc;
   int m_ir;
   int ready_mode = 0;
   int cyc_reads[$];
   int addr_reads[$];

   typedef struct {
      int pc; logic [7:0] hi; logic [7:0] lo; logic bc;
      int ir; int op; int alu; int rd; int ra; int rb; int imm; int npc;
   } vec_t;
   vec_t vecs[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int model_next(input int cur_pc, input int ir, input bit bc);
      int op;
      op = ir / 4096;
      if (op == 14 || (op == 15 && bc)) return ir % 256;
      return (cur_pc + 2) % 256;
   endfunction

   task automatic chk_ir(input string tag, input int exp_ir);
      chk({tag, "_ir"}, {16'h0, opcode, rd, ra, rb}, exp_ir);
      chk({tag, "_imm8"}, {24'h0, imm8}, exp_ir % 256);
      chk({tag, "_isaluop"}, {31'h0, isaluop}, (exp_ir < 32768) ? 1 : 0);
   endtask

   task automatic apply_reset(input bit use_pin);
      if (use_pin) reset = 1'b1; else do_reset = 1'b1;
      step();
      reset = 1'b0;
      do_reset = 1'b0;
      m_pc = 0;
      m_ir = 0;
      #1;
   endtask

   // Pulses do_fetch in cycle 0 and runs until fetch_stall drops; extra strobes at the given cycles.
   task automatic run_fetch(input int inj_fetch, input int inj_next, output int stall_cnt);
      int c;
      c = 0;
      stall_cnt = 0;
      cyc_reads.delete();
      addr_reads.delete();
      m_ir = mem[m_pc] * 256 + mem[(m_pc + 1) % 256];
      forever begin
         do_fetch = (c == 0) || (c == inj_fetch);
         do_next  = (c == inj_next);
`ifdef FETCH_WAIT_EN
         case (ready_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = ($urandom_range(0, 2) != 0);
            default: mem_ready = (c == 5 || c == 10);
         endcase
`endif
         #1;
         if (c == 0) chk("stall_cycle0", {31'h0, fetch_stall}, 1);
         else if (!fetch_stall) break;
         if (fetch_stall) stall_cnt++;
         if (mem_read) begin
            cyc_reads.push_back(c);
            addr_reads.push_back(int'(mem_addr));
         end
         if (c >= 60) begin
            vectors++;
            miscompares++;
            $display("FAIL fetch_timeout: stall still %0b after %0d cycles, required 0", fetch_stall, c);
            break;
         end
         step();
         c++;
      end
      do_fetch = 1'b0;
      do_next = 1'b0;
`ifdef FETCH_WAIT_EN
      mem_ready = 1'b1;
`endif
   endtask

   task automatic chk_reads(input int pc0, input int exp_cnt);
      if (exp_cnt >= 0) chk("read_count", cyc_reads.size(), exp_cnt);
      if (cyc_reads.size() > 0) begin
         chk("first_read_cycle", cyc_reads[0], 1);
         chk("first_read_addr", addr_reads[0], pc0);
         chk("last_read_addr", addr_reads[addr_reads.size() - 1], (pc0 + 1) % 256);
      end
   endtask

   task automatic do_next_op(input bit bc);
      branch_cond = bc;
      do_next = 1'b1;
      step();
      do_next = 1'b0;
      branch_cond = 1'b0;
      m_pc = model_next(m_pc, m_ir, bc);
      #1;
      chk("pc_after_next", {24'h0, pc}, m_pc);
   endtask

   task automatic goto_pc(input int target);
      int sc;
      if (m_pc != target) begin
         mem[m_pc] = 8'hE0;
         mem[(m_pc + 1) % 256] = 8'(target);
         run_fetch(-1, -1, sc);
         do_next_op(1'b0);
      end
   endtask

   // Loads a known IR, advances PC, then kills a fetch in HI_WAIT with reset or do_reset.
   task automatic abort_seq(input bit use_pin);
      int sc;
      apply_reset(1'b1);
      mem[0] = 8'h9C; mem[1] = 8'h3D; mem[2] = 8'h11; mem[3] = 8'h22;
      run_fetch(-1, -1, sc);
      chk_ir("abort_pre", 16'h9C3D);
      do_next_op(1'b0);
      do_fetch = 1'b1;
      step();
      do_fetch = 1'b0;
      step();
      chk("abort_in_hi_wait", {29'h0, fsm_state}, 2);
      if (use_pin) reset = 1'b1; else do_reset = 1'b1;
      step();
      reset = 1'b0;
      do_reset = 1'b0;
      m_pc = 0;
      m_ir = 0;
      #1;
      chk("abort_state", {29'h0, fsm_state}, 0);
      chk("abort_pc", {24'h0, pc}, 0);
      for (int i = 0; i < 4; i++) begin
         chk("abort_no_read", {31'h0, mem_read}, 0);
         chk_ir("abort_ir", 0);
         step();
      end
   endtask

   initial begin
      int sc;
      int p0;
      reset = 1'b1; do_fetch = 1'b0; do_next = 1'b0; do_reset = 1'b0; branch_cond = 1'b0;
`ifdef FETCH_WAIT_EN
      mem_ready = 1'b1;
`endif
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      step();
      step();
      reset = 1'b0;
      m_pc = 0;
      m_ir = 0;
      #1;
      chk("rst_pc", {24'h0, pc}, 0);
      chk_ir("rst", 0);
      chk("rst_mem_read", {31'h0, mem_read}, 0);
      chk("rst_mem_addr", {24'h0, mem_addr}, 0);
      chk("rst_stall", {31'h0, fetch_stall}, 0);
      chk("rst_proto_err", {31'h0, proto_err}, 0);
      chk("rst_state", {29'h0, fsm_state}, 0);

      vecs[0] = '{8'h00, 8'h12, 8'h34, 1'b0, 16'h1234, 1, 1, 2, 3, 4, 8'h34, 8'h02};
      vecs[1] = '{8'h10, 8'hE0, 8'h5A, 1'b0, 16'hE05A, 14, 0, 0, 5, 10, 8'h5A, 8'h5A};
      vecs[2] = '{8'h20, 8'hF0, 8'h7C, 1'b0, 16'hF07C, 15, 0, 0, 7, 12, 8'h7C, 8'h22};
      vecs[3] = '{8'h30, 8'hF0, 8'h7C, 1'b1, 16'hF07C, 15, 0, 0, 7, 12, 8'h7C, 8'h7C};
      vecs[4] = '{8'hFF, 8'hAB, 8'hCD, 1'b0, 16'hABCD, 10, 0, 11, 12, 13, 8'hCD, 8'h01};
      vecs[5] = '{8'hFE, 8'h7F, 8'h00, 1'b1, 16'h7F00, 7, 1, 15, 0, 0, 8'h00, 8'h00};
      vecs[6] = '{8'h40, 8'hE0, 8'h13, 1'b0, 16'hE013, 14, 0, 0, 1, 3, 8'h13, 8'h13};
      vecs[7] = '{8'h50, 8'h8F, 8'h21, 1'b1, 16'h8F21, 8, 0, 15, 2, 1, 8'h21, 8'h52};

      for (int i = 0; i < 8; i++) begin
         goto_pc(vecs[i].pc);
         mem[vecs[i].pc] = vecs[i].hi;
         mem[(vecs[i].pc + 1) % 256] = vecs[i].lo;
         p0 = m_pc;
         run_fetch(-1, -1, sc);
         chk("vec_stall_cycles", sc, 5);
         chk_reads(p0, EXP_READS);
         chk("vec_ir", {16'h0, opcode, rd, ra, rb}, vecs[i].ir);
         chk("vec_opcode", {28'h0, opcode}, vecs[i].op);
         chk("vec_isaluop", {31'h0, isaluop}, vecs[i].alu);
         chk("vec_rd", {28'h0, rd}, vecs[i].rd);
         chk("vec_ra", {28'h0, ra}, vecs[i].ra);
         chk("vec_rb", {28'h0, rb}, vecs[i].rb);
         chk("vec_imm8", {24'h0, imm8}, vecs[i].imm);
         chk("vec_pc_hold", {24'h0, pc}, vecs[i].pc);
         do_next_op(vecs[i].bc);
         chk("vec_npc", {24'h0, pc}, vecs[i].npc);
         chk("vec_proto_err", {31'h0, proto_err}, 0);
      end

      abort_seq(1'b1);
      abort_seq(1'b0);

      // Second do_fetch during LO_REQ must not restart or re-read.
      apply_reset(1'b1);
      mem[0] = 8'h21; mem[1] = 8'h43; mem[2] = 8'h65; mem[3] = 8'h87;
      run_fetch(3, -1, sc);
      chk_ir("refetch", 16'h2143);
      chk("refetch_reads", cyc_reads.size(), EXP_READS);
      chk("refetch_stall", sc, 5);
      chk("refetch_proto_err", {31'h0, proto_err}, 1);
      step();
      chk("refetch_idle_no_read", {31'h0, mem_read}, 0);
      do_next_op(1'b0);
      run_fetch(-1, -1, sc);
      chk_ir("refetch_next", 16'h6587);
      chk("proto_err_sticky", {31'h0, proto_err}, 1);
      apply_reset(1'b0);
      chk("proto_err_cleared", {31'h0, proto_err}, 0);

      // do_fetch and do_next together: PC moves, no fetch.
      do_fetch = 1'b1;
      do_next = 1'b1;
      step();
      do_fetch = 1'b0;
      do_next = 1'b0;
      m_pc = 2;
      #1;
      chk("both_pc", {24'h0, pc}, 2);
      chk("both_proto_err", {31'h0, proto_err}, 1);
      for (int i = 0; i < 3; i++) begin
         chk("both_state", {29'h0, fsm_state}, 0);
         chk("both_no_read", {31'h0, mem_read}, 0);
         step();
      end

      // do_next while busy is ignored.
      apply_reset(1'b1);
      mem[0] = 8'hE0; mem[1] = 8'h99;
      run_fetch(-1, 2, sc);
      chk("busy_next_pc", {24'h0, pc}, 0);
      chk("busy_next_proto_err", {31'h0, proto_err}, 1);
      chk_ir("busy_next", 16'hE099);

      // Randomized fetch/next against the reference model.
      apply_reset(1'b1);
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
`ifdef FETCH_WAIT_EN
      ready_mode = 1;
`endif
      for (int n = 0; n < 40; n++) begin
         bit bc;
         mem[m_pc] = 8'($urandom_range(0, 255));
         mem[(m_pc + 1) % 256] = 8'($urandom_range(0, 255));
         bc = 1'($urandom_range(0, 1));
         p0 = m_pc;
         run_fetch(-1, -1, sc);
         chk_ir("rnd", m_ir);
         chk_reads(p0, (ready_mode == 0) ? EXP_READS : -1);
         do_next_op(bc);
      end
      chk("rnd_proto_err", {31'h0, proto_err}, 0);
      ready_mode = 0;

`ifdef FETCH_WAIT_EN
      // Three not-ready cycles in each wait state.
      apply_reset(1'b1);
      mem[0] = 8'hC3; mem[1] = 8'h5E;
      ready_mode = 2;
      run_fetch(-1, -1, sc);
      ready_mode = 0;
      chk_ir("wait", 16'hC35E);
      chk("wait_stall_cycles", sc, 11);
      chk("wait_read_count", cyc_reads.size(), 10);
      for (int i = 0; i < cyc_reads.size(); i++)
         chk("wait_read_addr", addr_reads[i], (cyc_reads[i] <= 5) ? 0 : 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
